spook_bus_arbiter: RTL and testbench

SPOOK_BUS_ARBITER -- requirements
Module: spook_bus_arbiter

---
 rtl/spook_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_spook_bus_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spook_bus_arbiter.sv
// ---------------------------------------------------------------------------
// spook_bus_arbiter
//
// Shares a single Spook core between two requesters. One requester is
// granted at a time. Its instruction/header/data words are forwarded to the
// core's bus_in, and the core's bus_out words are returned to it. A
// transaction ends once both the final input word and the final output word
// have been accepted. Under contention, grants alternate between the two
// requesters.
//
// Ports
//   clk, rst                   clock; synchronous active-low reset
//   reqX_data/valid/last       request stream from requester X (X = 0, 1)
//   reqX_ready                 request word accepted when valid & ready
//   core_bus_in/_valid         word and valid towards the core bus_in
//   core_ready_bus_in          core ready on bus_in
//   core_bus_out/_valid/_last  response stream from the core
//   core_ready_bus_out         ready towards the core bus_out
//   rspX_data/valid/last       response stream to requester X
//   rspX_ready                 requester X accepts the response word
//   owner                      requester currently (or most recently) granted
//   busy                       high whenever the FSM is not IDLE
//   tx_count                   completed transactions since reset (wraps)
// ---------------------------------------------------------------------------
module spook_bus_arbiter #(
  parameter int BUS_SIZE = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BUS_SIZE-1:0] req0_data,
  input  logic                req0_valid,
  input  logic                req0_last,
  output logic                req0_ready,
  input  logic [BUS_SIZE-1:0] req1_data,
  input  logic                req1_valid,
  input  logic                req1_last,
  output logic                req1_ready,
  output logic [BUS_SIZE-1:0] core_bus_in,
  output logic                core_bus_in_valid,
  input  logic                core_ready_bus_in,
  input  logic [BUS_SIZE-1:0] core_bus_out,
  input  logic                core_bus_out_valid,
  input  logic                core_bus_out_last,
  output logic                core_ready_bus_out,
  output logic [BUS_SIZE-1:0] rsp0_data,
  output logic                rsp0_valid,
  output logic                rsp0_last,
  input  logic                rsp0_ready,
  output logic [BUS_SIZE-1:0] rsp1_data,
  output logic                rsp1_valid,
  output logic                rsp1_last,
  input  logic                rsp1_ready,
  output logic                owner,
  output logic                busy,
  output logic [15:0]         tx_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    WAIT_RSP = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t state, state_next;
  logic   owner_next;
  logic   prio;          // requester that wins the next contended grant
  logic   in_done;       // final input word of this transaction accepted
  logic   out_done;      // final output word of this transaction accepted
  logic   in_last_acc;   // final input word accepted this cycle
  logic   out_last_acc;  // final output word accepted this cycle
  logic   sel_valid, sel_last, sel_rsp_ready;
  logic   in_open, out_open;

  // Both requesters see the core output word; only the owner sees valid.
  assign rsp0_data = core_bus_out;
  assign rsp1_data = core_bus_out;
  assign busy      = (state != IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case/if structure can leave a value held (latch).
    state_next         = state;
    owner_next         = owner;
    core_bus_in        = owner ? req1_data : req0_data;
    core_bus_in_valid  = 1'b0;
    req0_ready         = 1'b0;
    req1_ready         = 1'b0;
    rsp0_valid         = 1'b0;
    rsp1_valid         = 1'b0;
    rsp0_last          = 1'b0;
    rsp1_last          = 1'b0;
    core_ready_bus_out = 1'b0;
    in_last_acc        = 1'b0;
    out_last_acc       = 1'b0;

    sel_valid     = owner ? req1_valid : req0_valid;
    sel_last      = owner ? req1_last  : req0_last;
    sel_rsp_ready = owner ? rsp1_ready : rsp0_ready;

    // The input path closes once the last input word is accepted; the
    // output path likewise closes independently on the last output word.
    in_open  = (state == ACTIVE) && !in_done;
    out_open = ((state == ACTIVE) || (state == WAIT_RSP)) && !out_done;

    if (in_open) begin
      core_bus_in_valid = sel_valid;
      req0_ready        = !owner && core_ready_bus_in;
      req1_ready        =  owner && core_ready_bus_in;
      in_last_acc       = sel_valid && core_ready_bus_in && sel_last;
    end

    if (out_open) begin
      rsp0_valid         = !owner && core_bus_out_valid;
      rsp1_valid         =  owner && core_bus_out_valid;
      rsp0_last          = !owner && core_bus_out_last;
      rsp1_last          =  owner && core_bus_out_last;
      core_ready_bus_out = sel_rsp_ready;
      out_last_acc       = core_bus_out_valid && sel_rsp_ready && core_bus_out_last;
    end

    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          state_next = ACTIVE;
          owner_next = (req0_valid && req1_valid) ? prio : req1_valid;
        end
      end
      ACTIVE: begin
        // The core may finish its output before the input is complete; the
        // FSM then stays here until the input side also completes.
        if ((in_done || in_last_acc) && (out_done || out_last_acc))
          state_next = RELEASE;
        else if (in_done || in_last_acc)
          state_next = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (out_last_acc)
          state_next = RELEASE;
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      prio     <= 1'b0;
      in_done  <= 1'b0;
      out_done <= 1'b0;
      tx_count <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      if (in_last_acc)  in_done  <= 1'b1;
      if (out_last_acc) out_done <= 1'b1;
      if (state == RELEASE) begin
        tx_count <= tx_count + 16'd1;
        prio     <= ~owner;
        in_done  <= 1'b0;
        out_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spook_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spook_bus_arbiter
//
// Randomized transaction-level bench. The bench acts as both requesters and
// the core. The reference model tracks the transaction as word indices into
// queues of expected words, plus a grant-priority bit and a transaction
// counter. Outputs are sampled 1 time unit after the falling edge, when the
// inputs for that cycle are settled.
// ---------------------------------------------------------------------------
module tb_spook_bus_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_valid, req0_last, req0_ready;
  logic         req1_valid, req1_last, req1_ready;
  logic [W-1:0] core_bus_in;
  logic         core_bus_in_valid, core_ready_bus_in;
  logic [W-1:0] core_bus_out;
  logic         core_bus_out_valid, core_bus_out_last, core_ready_bus_out;
  logic [W-1:0] rsp0_data, rsp1_data;
  logic         rsp0_valid, rsp0_last, rsp0_ready;
  logic         rsp1_valid, rsp1_last, rsp1_ready;
  logic         owner, busy;
  logic [15:0]  tx_count;

  always #5 clk = ~clk;

  spook_bus_arbiter #(.BUS_SIZE(W)) dut (
    .clk(clk), .rst(rst),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .core_bus_in(core_bus_in), .core_bus_in_valid(core_bus_in_valid),
    .core_ready_bus_in(core_ready_bus_in),
    .core_bus_out(core_bus_out), .core_bus_out_valid(core_bus_out_valid),
    .core_bus_out_last(core_bus_out_last), .core_ready_bus_out(core_ready_bus_out),
    .rsp0_data(rsp0_data), .rsp0_valid(rsp0_valid), .rsp0_last(rsp0_last), .rsp0_ready(rsp0_ready),
    .rsp1_data(rsp1_data), .rsp1_valid(rsp1_valid), .rsp1_last(rsp1_last), .rsp1_ready(rsp1_ready),
    .owner(owner), .busy(busy), .tx_count(tx_count)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  bit          prio_m = 1'b0;
  logic [15:0] tx_m   = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit chance(input int pct);
    return int'($urandom_range(0, 99)) < pct;
  endfunction

  task automatic idle_inputs();
    req0_valid = 0; req0_last = 0; req0_data = $urandom;
    req1_valid = 0; req1_last = 0; req1_data = $urandom;
    core_ready_bus_in  = 0;
    core_bus_out_valid = 0; core_bus_out_last = 0; core_bus_out = $urandom;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic all_high();
    req0_valid = 1; req0_last = 1; req1_valid = 1; req1_last = 1;
    core_ready_bus_in  = 1;
    core_bus_out_valid = 1; core_bus_out_last = 1;
    rsp0_ready = 1; rsp1_ready = 1;
  endtask

  task automatic check_quiet(input string tag);
    check(tag, {req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                core_bus_in_valid, core_ready_bus_out}, 6'b0);
  endtask

  task automatic drive_req(input bit which, input logic v, input logic [W-1:0] d, input logic l);
    if (which) begin req1_valid = v; req1_data = d; req1_last = l; end
    else       begin req0_valid = v; req0_data = d; req0_last = l; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    all_high();
    repeat (2) @(posedge clk);
    #1;
    check("rst_quiet", {req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                        core_bus_in_valid, core_ready_bus_out}, 6'b0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_count", tx_count, 0);
    @(negedge clk);
    rst = 1;
    idle_inputs();
    prio_m = 0;
    tx_m   = '0;
  endtask

  // One transaction. r0/r1: which requesters ask; pct: handshake probability;
  // out_first: hold the input until all output words are delivered;
  // abort_wait: reset the arbiter once the input is done (WAIT_RSP).
  task automatic run_txn(input bit r0, input bit r1, input int n_in, input int n_out,
                         input int pct, input bit out_first, input bit abort_wait);
    bit           w;
    logic [W-1:0] in_w[$];
    logic [W-1:0] out_w[$];
    int           i, j, cyc;
    bit           wv, cov, rr, in_ph, out_ph;
    w = (r0 && r1) ? prio_m : r1;
    for (int k = 0; k < n_in; k++)  in_w.push_back($urandom);
    for (int k = 0; k < n_out; k++) out_w.push_back($urandom);
    i = 0; j = 0; cyc = 0;

    // Request cycle in IDLE: grant appears after this edge.
    @(negedge clk);
    idle_inputs();
    req0_valid = r0; req1_valid = r1;
    req0_last = $urandom; req1_last = $urandom;
    drive_req(w, 1'b1, in_w[0], n_in == 1);
    @(posedge clk); #1;
    check("grant_owner", owner, w);
    check("grant_busy", busy, 1);

    while (i < n_in || j < n_out) begin
      if (abort_wait && i == n_in) begin
        @(negedge clk);
        check("pre_abort_busy", busy, 1);
        rst = 0;
        all_high();
        @(posedge clk); #1;
        check_quiet("abort_quiet");
        check("abort_busy", busy, 0);
        check("abort_count", tx_count, 0);
        check("abort_owner", owner, 0);
        @(negedge clk);
        rst = 1;
        idle_inputs();
        prio_m = 0;
        tx_m   = '0;
        return;
      end
      @(negedge clk);
      in_ph  = (i < n_in);
      out_ph = (j < n_out);
      // Loser keeps its request up with junk data; it must have no effect.
      drive_req(!w, w ? r0 : r1, $urandom, $urandom);
      // After the last word, junk valids probe that the path stays closed.
      wv = in_ph ? (!(out_first && out_ph) && chance(pct)) : chance(50);
      drive_req(w, wv, in_ph ? in_w[i] : W'($urandom), in_ph ? (i == n_in - 1) : 1'b1);
      core_ready_bus_in  = chance(pct);
      cov = out_ph ? (!abort_wait && chance(pct)) : chance(50);
      core_bus_out_valid = cov;
      core_bus_out       = out_ph ? out_w[j] : W'($urandom);
      core_bus_out_last  = out_ph ? (j == n_out - 1) : 1'b1;
      rr = chance(pct);
      if (w) begin rsp1_ready = rr; rsp0_ready = $urandom; end
      else   begin rsp0_ready = rr; rsp1_ready = $urandom; end
      #1;
      check("cbi_valid", core_bus_in_valid, in_ph && wv);
      if (in_ph && wv) check("cbi_data", core_bus_in, in_w[i]);
      check("win_ready", w ? req1_ready : req0_ready, in_ph && core_ready_bus_in);
      check("lose_ready", w ? req0_ready : req1_ready, 0);
      if (out_ph) begin
        check("win_rsp_valid", w ? rsp1_valid : rsp0_valid, cov);
        check("win_rsp_last", w ? rsp1_last : rsp0_last, core_bus_out_last);
      end
      check("lose_rsp_valid", w ? rsp0_valid : rsp1_valid, 0);
      check("cbo_ready", core_ready_bus_out, out_ph && rr);
      check("rsp0_data", rsp0_data, core_bus_out);
      check("rsp1_data", rsp1_data, core_bus_out);
      check("act_busy", busy, 1);
      check("act_owner", owner, w);
      @(posedge clk);
      if (in_ph && wv && core_ready_bus_in) i++;
      if (out_ph && cov && rr) j++;
      cyc++;
      if (cyc > 1000) begin
        check("txn_timeout", cyc, 0);
        break;
      end
    end

    // Both sides done: one RELEASE cycle, then IDLE.
    #1; all_high();
    #1;
    check_quiet("rel_quiet");
    check("rel_busy", busy, 1);
    check("rel_count", tx_count, tx_m);
    @(posedge clk); #1;
    tx_m   = tx_m + 16'd1;
    prio_m = !w;
    check_quiet("idle_quiet");
    check("idle_busy", busy, 0);
    check("idle_count", tx_count, tx_m);
    check("idle_owner", owner, w);
    idle_inputs();
  endtask

  initial begin
    bit r0, r1;
    rst = 0;
    idle_inputs();
    do_reset();

    // Single requester: 3 input words, 2 response words.
    run_txn(1, 0, 3, 2, 100, 0, 0);
    check("single_count", tx_count, 1);
    check("single_owner", owner, 0);
    run_txn(0, 1, 2, 4, 100, 0, 0);

    // Continuous contention straight after reset: grants 0,1,0,1.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      run_txn(1, 1, 2, 2, 100, 0, 0);
      check("rr_grant", owner, k % 2);
    end
    check("rr_count", tx_count, 4);

    // Output last before input last.
    run_txn(1, 0, 3, 2, 100, 1, 0);
    run_txn(0, 1, 2, 3, 70, 1, 0);
    run_txn(1, 1, 1, 1, 100, 1, 0);

    // Random mix with back-pressure.
    for (int k = 0; k < 40; k++) begin
      r0 = $urandom; r1 = $urandom;
      if (!r0 && !r1) r0 = 1;
      run_txn(r0, r1, $urandom_range(1, 6), $urandom_range(1, 5),
              $urandom_range(35, 100), chance(15), 0);
    end

    // Reset while waiting for the response, then contention starts at 0.
    run_txn(1, 1, 2, 3, 100, 0, 1);
    run_txn(1, 1, 1, 1, 100, 0, 0);
    check("post_abort_grant", owner, 0);

    // Counter wrap: preset near the top, then two transactions.
    force dut.tx_count = 16'hFFFE;
    #1;
    release dut.tx_count;
    tx_m = 16'hFFFE;
    check("preset_count", tx_count, 16'hFFFE);
    run_txn(1, 0, 1, 1, 100, 0, 0);
    run_txn(0, 1, 1, 1, 100, 0, 0);
    check("wrap_count", tx_count, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
